// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 constants, word type and access-decode helpers
//
// Purpose: common definitions for the SEQ datapath stages.
//   - icode constants I_HALT..I_POPQ
//   - stat codes STAT_AOK/HLT/ADR/INS
//   - word_t: 64-bit machine word
//   - is_mem_read/is_mem_write: which icodes touch data memory
package y86_pkg;

   typedef logic [63:0] word_t;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   function automatic logic is_mem_read(input logic [3:0] icode);
      return (icode == I_MRMOVQ) || (icode == I_RET) || (icode == I_POPQ);
   endfunction

   function automatic logic is_mem_write(input logic [3:0] icode);
      return (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
   endfunction

endpackage

// File: rtl/dmem.sv
// rtl/dmem.sv - byte-addressed little-endian data memory, 8-byte ports
//
// Purpose: MEM_BYTES byte array with one combinational 8-byte read port,
// one synchronous 8-byte write port and one word-aligned clear port.
// Ports:
//   i_clk       clock, rising edge
//   i_rd_addr   byte address of read (bits [7:0] of o_rd_data come from it)
//   o_rd_data   8-byte little-endian read data, combinational
//   i_wr_en     functional write enable
//   i_wr_addr   byte address of write, any alignment
//   i_wr_data   8-byte little-endian write data
//   i_clr_en    clear-write enable, wins over a functional write
//   i_clr_word  index of the 8-byte word to zero
module dmem
   import y86_pkg::*;
#(
   parameter int MEM_BYTES = 1024
) (
   input  logic                           i_clk,
   input  logic [$clog2(MEM_BYTES)-1:0]   i_rd_addr,
   output word_t                          o_rd_data,
   input  logic                           i_wr_en,
   input  logic [$clog2(MEM_BYTES)-1:0]   i_wr_addr,
   input  word_t                          i_wr_data,
   input  logic                           i_clr_en,
   input  logic [$clog2(MEM_BYTES)-4:0]   i_clr_word
);

   localparam int AW = $clog2(MEM_BYTES);

   logic [7:0] r_mem [MEM_BYTES];

   // Byte indices wrap modulo the array size; the stage never presents an
   // address whose 8 bytes run off the end while the data is used.
   always_comb begin
      o_rd_data = '0;
      for (int k = 0; k < 8; k++) begin
         o_rd_data[8*k +: 8] = r_mem[i_rd_addr + AW'(k)];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_clr_en) begin
         for (int k = 0; k < 8; k++) begin
            r_mem[{i_clr_word, 3'(k)}] <= 8'h00;
         end
      end else if (i_wr_en) begin
         for (int k = 0; k < 8; k++) begin
            r_mem[i_wr_addr + AW'(k)] <= i_wr_data[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 SEQ memory stage with clear sweep and error flag
//
// Purpose: performs the one data-memory access implied by icode, range
// checks it, returns valM combinationally, and clears the memory after reset.
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-high reset; restarts the clear sweep
//   icode       instruction code selecting the access
//   valA        store data, or address for ret/popq
//   valE        address for rmmovq/mrmovq/call/pushq
//   valP        return address stored by call
//   valM        read data, 0 when no legal read (combinational)
//   dmem_error  current access out of range (combinational)
//   err_sticky  set by any dmem_error while ready, cleared by reset only
//   ready       0 during the clear sweep, 1 afterwards
module memory_stage
   import y86_pkg::*;
#(
   parameter int MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  icode,
   input  word_t       valA,
   input  word_t       valE,
   input  word_t       valP,
   output word_t       valM,
   output logic        dmem_error,
   output logic        err_sticky,
   output logic        ready
);

   localparam int    AW        = $clog2(MEM_BYTES);
   localparam int    WORDS     = MEM_BYTES / 8;
   localparam int    CW        = AW - 3;
   localparam word_t LAST_ADDR = word_t'(MEM_BYTES - 8);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_clr_cnt;
   logic            r_ready;
   logic            r_err_sticky;

   logic            w_is_rd;
   logic            w_is_wr;
   word_t           w_addr;
   word_t           w_wdata;
   logic            w_oob;
   logic            w_err;
   logic            w_wr_en;
   logic            w_clr_en;
   word_t           w_rd_data;

   // ret/popq address through valA (old stack pointer); everything else
   // uses the ALU result. Only call stores something other than valA.
   always_comb begin
      w_is_rd = is_mem_read(icode);
      w_is_wr = is_mem_write(icode);
      w_addr  = ((icode == I_RET) || (icode == I_POPQ)) ? valA : valE;
      w_wdata = (icode == I_CALL) ? valP : valA;
   end

   // Full 64-bit compare: huge addresses must not alias low memory.
   assign w_oob    = (w_addr > LAST_ADDR);
   assign w_err    = r_ready && (w_is_rd || w_is_wr) && w_oob;
   assign w_wr_en  = r_ready && w_is_wr && !w_oob && !reset;
   assign w_clr_en = (r_state == S_CLEAR);

   dmem #(
      .MEM_BYTES (MEM_BYTES)
   ) u_dmem (
      .i_clk      (clk),
      .i_rd_addr  (w_addr[AW-1:0]),
      .o_rd_data  (w_rd_data),
      .i_wr_en    (w_wr_en),
      .i_wr_addr  (w_addr[AW-1:0]),
      .i_wr_data  (w_wdata),
      .i_clr_en   (w_clr_en),
      .i_clr_word (r_clr_cnt)
   );

   assign valM       = (r_ready && w_is_rd && !w_oob) ? w_rd_data : '0;
   assign dmem_error = w_err;
   assign err_sticky = r_err_sticky;
   assign ready      = r_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_CLEAR;
         r_clr_cnt    <= '0;
         r_ready      <= 1'b0;
         r_err_sticky <= 1'b0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_clr_cnt <= r_clr_cnt + CW'(1);
               if (r_clr_cnt == CW'(WORDS - 1)) begin
                  r_state <= S_RUN;
                  r_ready <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_err) begin
                  r_err_sticky <= 1'b1;
               end
            end
            default: begin
               r_state <= S_CLEAR;
            end
         endcase
      end
   end

endmodule
